// File: rtl/fm_demodulate_if.sv
// FIFO-side handshake bundle for the FM discriminator: two show-ahead input FIFOs (I, Q) and one output FIFO.
// master = discriminator side, slave = FIFO side.
interface fm_demodulate_if #(
  parameter int DATA_SIZE = 32
);
  logic                 i_empty;
  logic                 i_rd_en;
  logic [DATA_SIZE-1:0] i_dout;
  logic                 q_empty;
  logic                 q_rd_en;
  logic [DATA_SIZE-1:0] q_dout;
  logic                 out_full;
  logic                 out_wr_en;
  logic [DATA_SIZE-1:0] out_din;

  modport master (
    input  i_empty, i_dout, q_empty, q_dout, out_full,
    output i_rd_en, q_rd_en, out_wr_en, out_din
  );

  modport slave (
    output i_empty, i_dout, q_empty, q_dout, out_full,
    input  i_rd_en, q_rd_en, out_wr_en, out_din
  );
endinterface

// File: rtl/fm_demodulate.sv
// FM discriminator: quantized phase difference of consecutive I/Q samples, scaled by the demod gain.
// One sample in flight; a restoring divider produces one quotient bit per cycle.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | wait for both FIFOs non-empty, pop one I/Q pair
// S_MULT  | cross products -> x (real), y (imag) of cur * conj(prev)
// S_SETUP | build numerator/denominator/base angle, load divider
// S_DIV   | 2*DATA_SIZE restoring divide steps
// S_ANGLE | angle = base - QUAD1*r, sign from y
// S_GAIN  | scale by demod gain
// S_WRITE | push result, stall while output FIFO full
module fm_demodulate #(
  parameter int DATA_SIZE = 32,
  parameter int BITS      = 10,
  parameter int GAIN      = 758,
  parameter int QUAD1     = 804,
  parameter int QUAD3     = 2412
) (
  input logic             clock,
  input logic             reset,
  fm_demodulate_if.master bus
);

  localparam int W2 = 2 * DATA_SIZE;
  localparam int CW = $clog2(W2);
  localparam logic [CW-1:0]                DIV_LAST = CW'(W2 - 1);
  localparam logic signed [W2-1:0]         QMASK    = W2'((1 << BITS) - 1);
  localparam logic signed [W2-1:0]         GAIN_W   = W2'(GAIN);
  localparam logic signed [W2-1:0]         QUAD1_W  = W2'(QUAD1);
  localparam logic signed [DATA_SIZE-1:0]  QUAD1_D  = DATA_SIZE'(QUAD1);
  localparam logic signed [DATA_SIZE-1:0]  QUAD3_D  = DATA_SIZE'(QUAD3);

  typedef enum logic [2:0] {
    S_IDLE, S_MULT, S_SETUP, S_DIV, S_ANGLE, S_GAIN, S_WRITE
  } state_t;

  function automatic logic signed [W2-1:0] sx(input logic signed [DATA_SIZE-1:0] v);
    return {{DATA_SIZE{v[DATA_SIZE-1]}}, v};
  endfunction

  // Dequantize with truncation toward zero: bias negatives before the arithmetic shift.
  function automatic logic signed [DATA_SIZE-1:0] deq(input logic signed [W2-1:0] v);
    return DATA_SIZE'(v[W2-1] ? (v + QMASK) >>> BITS : v >>> BITS);
  endfunction

  state_t                       state;
  logic signed [DATA_SIZE-1:0]  cur_i, cur_q, prev_i, prev_q;
  logic signed [DATA_SIZE-1:0]  x_r, y_r, base_r, angle_r, result_r;
  logic        [DATA_SIZE-1:0]  den_r;
  logic                         num_neg;
  logic        [W2-1:0]         quo_r;
  logic        [DATA_SIZE-1:0]  rem_r;
  logic        [CW-1:0]         div_cnt;

  logic signed [DATA_SIZE-1:0]  x_nxt, y_nxt, abs_y, num_base, den_nxt, base_nxt;
  logic signed [DATA_SIZE-1:0]  angle_t, angle_nxt, result_nxt;
  logic signed [W2-1:0]         num_full, num_mag, r_val;
  logic        [DATA_SIZE:0]    div_shift;
  logic                         div_ge;

  always_comb begin
    x_nxt = deq(sx(prev_i) * sx(cur_i)) - deq(-(sx(prev_q) * sx(cur_q)));
    y_nxt = deq(sx(prev_i) * sx(cur_q)) + deq(-(sx(prev_q) * sx(cur_i)));

    abs_y = (y_r[DATA_SIZE-1] ? -y_r : y_r) + DATA_SIZE'(1);
    if (!x_r[DATA_SIZE-1]) begin
      num_base = x_r - abs_y;
      den_nxt  = x_r + abs_y;
      base_nxt = QUAD1_D;
    end else begin
      num_base = x_r + abs_y;
      den_nxt  = abs_y - x_r;
      base_nxt = QUAD3_D;
    end
    num_full = sx(num_base) <<< BITS;
    num_mag  = num_full[W2-1] ? -num_full : num_full;

    div_shift = {rem_r, quo_r[W2-1]};
    div_ge    = div_shift >= {1'b0, den_r};

    r_val     = num_neg ? -quo_r : quo_r;
    angle_t   = base_r - deq(QUAD1_W * r_val);
    angle_nxt = y_r[DATA_SIZE-1] ? -angle_t : angle_t;

    result_nxt = deq(GAIN_W * sx(angle_r));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      bus.i_rd_en   <= 1'b0;
      bus.q_rd_en   <= 1'b0;
      bus.out_wr_en <= 1'b0;
      bus.out_din   <= '0;
      cur_i         <= '0;
      cur_q         <= '0;
      prev_i        <= '0;
      prev_q        <= '0;
      x_r           <= '0;
      y_r           <= '0;
      base_r        <= '0;
      den_r         <= '0;
      num_neg       <= 1'b0;
      quo_r         <= '0;
      rem_r         <= '0;
      div_cnt       <= '0;
      angle_r       <= '0;
      result_r      <= '0;
    end else begin
      bus.i_rd_en   <= 1'b0;
      bus.q_rd_en   <= 1'b0;
      bus.out_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!bus.i_empty && !bus.q_empty) begin
            bus.i_rd_en <= 1'b1;
            bus.q_rd_en <= 1'b1;
            prev_i      <= cur_i;
            prev_q      <= cur_q;
            cur_i       <= bus.i_dout;
            cur_q       <= bus.q_dout;
            state       <= S_MULT;
          end
        end
        S_MULT: begin
          x_r   <= x_nxt;
          y_r   <= y_nxt;
          state <= S_SETUP;
        end
        S_SETUP: begin
          den_r   <= den_nxt;
          base_r  <= base_nxt;
          num_neg <= num_full[W2-1];
          quo_r   <= num_mag;
          rem_r   <= '0;
          div_cnt <= DIV_LAST;
          state   <= S_DIV;
        end
        S_DIV: begin
          quo_r <= {quo_r[W2-2:0], div_ge};
          rem_r <= div_ge ? DATA_SIZE'(div_shift - {1'b0, den_r}) : div_shift[DATA_SIZE-1:0];
          if (div_cnt == '0) state <= S_ANGLE;
          else               div_cnt <= div_cnt - CW'(1);
        end
        S_ANGLE: begin
          angle_r <= angle_nxt;
          state   <= S_GAIN;
        end
        S_GAIN: begin
          result_r <= result_nxt;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          // out_din presents the result even while stalled on a full FIFO
          bus.out_din <= result_r;
          if (!bus.out_full) begin
            bus.out_wr_en <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
